// File: rtl/mul_pkg.sv
// Shared multiplier definitions: operand width, counter width and the controller command bundle.
// Used by both this datapath and the Control_MUL sequencer.
package mul_pkg;

  localparam int MUL_N     = 16;
  localparam int MUL_CNT_W = $clog2(MUL_N);

  typedef struct packed {
    logic load;
    logic ad;
    logic sh;
    logic done;
  } mul_cmd_t;

  // Counter width for an N-bit operand; never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_shift_counter.sv
// Shift counter: clears on rst/load, advances on every shift, decodes k one shift before the last.
// Single-cycle update; no backpressure, commands are always accepted.
module mul_shift_counter
  import mul_pkg::*;
#(
  parameter int N = MUL_N
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic sh,
  output logic k
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt;

  // Wraps modulo 2^CW; extra shifts from a faulty controller simply keep counting.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (sh) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign k = (cnt == LAST);

endmodule

// File: rtl/mul_datapath.sv
// Shift-and-add multiplier datapath executing Load/Ad/Sh/Done; every command lands at its sampling edge.
// No backpressure: the controller owns sequencing, M and k are register-only status back to it.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int N = MUL_N
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Load,
  input  logic           Ad,
  input  logic           Sh,
  input  logic           Done,
  input  logic [N-1:0]   Mplier,
  input  logic [N-1:0]   Mcand,
  output logic           M,
  output logic           k,
  output logic [2*N-1:0] Product,
  output logic           Valid
);

  mul_cmd_t       cmd;
  logic [2*N:0]   acc;
  logic [2*N:0]   acc_nxt;
  logic [2*N:0]   acc_sum;
  logic [N:0]     upper_sum;
  logic [N-1:0]   mc;

  assign cmd = '{load: Load, ad: Ad, sh: Sh, done: Done};

  // The add reads ACC[2N-1:N] only; the old carry bit is always dropped.
  always_comb begin
    upper_sum = {1'b0, acc[2*N-1:N]} + {1'b0, mc};
    acc_sum   = {upper_sum, acc[N-1:0]};
    acc_nxt   = acc;
    if (cmd.load) begin
      acc_nxt = {{(N+1){1'b0}}, Mplier};
    end else if (cmd.ad && cmd.sh) begin
      acc_nxt = {1'b0, acc_sum[2*N:1]};
    end else if (cmd.ad) begin
      acc_nxt = acc_sum;
    end else if (cmd.sh) begin
      acc_nxt = {1'b0, acc[2*N:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc     <= '0;
      mc      <= '0;
      Product <= '0;
      Valid   <= 1'b0;
    end else begin
      acc <= acc_nxt;
      if (cmd.load) begin
        mc <= Mcand;
      end
      // Done samples the pre-command ACC, independent of any Ad/Sh in the same cycle.
      if (cmd.done) begin
        Product <= acc[2*N-1:0];
        Valid   <= 1'b1;
      end else begin
        Valid   <= 1'b0;
      end
    end
  end

  assign M = acc[0];

  mul_shift_counter #(.N(N)) u_cnt (
    .clk  (Clk),
    .rst  (Rst),
    .load (cmd.load),
    .sh   (cmd.sh),
    .k    (k)
  );

endmodule

// File: tb/tb_mul_datapath.sv
// Self-checking bench for mul_datapath at N=16 and N=4 against an arithmetic reference model.
// A bench-side controller drives Load/Ad/Sh/Done; expected values come from plain multiplication.
module tb_mul_datapath;

  localparam int N = 16;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Load = 1'b0, Ad = 1'b0, Sh = 1'b0, Done = 1'b0;
  logic [15:0]   Mplier = '0, Mcand = '0;
  logic          M, k;
  logic [31:0]   Product;
  logic          Valid;

  logic          ld4 = 1'b0, ad4 = 1'b0, sh4 = 1'b0, dn4 = 1'b0;
  logic [3:0]    mp4 = '0, mc4 = '0;
  logic          m4, k4;
  logic [7:0]    prod4;
  logic          vld4;

  int ncheck = 0;
  int npass  = 0;
  logic [31:0] exp_last;

  always #5 Clk = ~Clk;

  mul_datapath #(.N(16)) dut (
    .Clk(Clk), .Rst(Rst), .Load(Load), .Ad(Ad), .Sh(Sh), .Done(Done),
    .Mplier(Mplier), .Mcand(Mcand), .M(M), .k(k), .Product(Product), .Valid(Valid)
  );

  mul_datapath #(.N(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Load(ld4), .Ad(ad4), .Sh(sh4), .Done(dn4),
    .Mplier(mp4), .Mcand(mc4), .M(m4), .k(k4), .Product(prod4), .Valid(vld4)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // After i shift-and-add iterations the low 2N bits hold b*(a mod 2^i) aligned at N-i, over a>>i.
  function automatic logic [31:0] model_partial(input logic [15:0] a, input logic [15:0] b, input int i);
    logic [31:0] lowa;
    logic [31:0] p;
    lowa = 32'(a) & ((32'd1 << i) - 32'd1);
    p    = 32'(b) * lowa;
    return (p << (16 - i)) + (32'(a) >> i);
  endfunction

  // Bench-side controller for the N=16 instance; records M and k seen before each shift.
  task automatic mult16(input logic [15:0] a, input logic [15:0] b, input bit comb, input bit do_load,
                        output logic [15:0] mb, output logic [15:0] kb, output int nadd);
    nadd = 0;
    mb   = '0;
    kb   = '0;
    if (do_load) begin
      Load = 1'b1; Mplier = a; Mcand = b;
      tick();
      Load = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      mb[i] = M;
      kb[i] = k;
      if (M) begin
        nadd++;
        if (comb) begin
          Ad = 1'b1; Sh = 1'b1; tick();
        end else begin
          Ad = 1'b1; tick(); Ad = 1'b0; Sh = 1'b1; tick();
        end
      end else begin
        Sh = 1'b1; tick();
      end
      Ad = 1'b0; Sh = 1'b0;
    end
    Done = 1'b1;
    tick();
    Done = 1'b0;
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      {Load, Ad, Sh, Done} = 4'($urandom);
      {ld4, ad4, sh4, dn4} = 4'($urandom);
      Mplier = 16'($urandom); Mcand = 16'($urandom);
      mp4 = 4'($urandom); mc4 = 4'($urandom);
      tick();
    end
    ncheck++; if (Product !== 32'd0) $display("FAIL reset_product got %0h expected 0", Product); else npass++;
    ncheck++; if (Valid !== 1'b0) $display("FAIL reset_valid got %b expected 0", Valid); else npass++;
    ncheck++; if (M !== 1'b0) $display("FAIL reset_m got %b expected 0", M); else npass++;
    ncheck++; if (k !== 1'b0) $display("FAIL reset_k got %b expected 0", k); else npass++;
    ncheck++; if ({prod4, vld4, m4, k4} !== 11'd0) $display("FAIL reset_n4 got %0h expected 0", {prod4, vld4, m4, k4}); else npass++;
    Rst = 1'b0;
    {Load, Ad, Sh, Done} = '0;
    {ld4, ad4, sh4, dn4} = '0;
    tick();
  endtask

  task automatic test_normal_n4;
    logic [3:0] mb, kb;
    logic [7:0] exp;
    exp = 8'(13 * 11);
    ld4 = 1'b1; mp4 = 4'd13; mc4 = 4'd11;
    tick();
    ld4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mb[i] = m4;
      kb[i] = k4;
      if (m4) begin
        ad4 = 1'b1; tick(); ad4 = 1'b0;
      end
      sh4 = 1'b1; tick(); sh4 = 1'b0;
    end
    ncheck++; if (mb !== 4'b1101) $display("FAIL n4_m_pattern got %b expected 1101", mb); else npass++;
    ncheck++; if (kb !== 4'b1000) $display("FAIL n4_k_pattern got %b expected 1000", kb); else npass++;
    ncheck++; if (k4 !== 1'b0) $display("FAIL n4_k_wrap got %b expected 0", k4); else npass++;
    dn4 = 1'b1; tick(); dn4 = 1'b0;
    ncheck++; if (vld4 !== 1'b1) $display("FAIL n4_valid got %b expected 1", vld4); else npass++;
    ncheck++; if (prod4 !== exp) $display("FAIL n4_product got %0d expected %0d", prod4, exp); else npass++;
    tick();
    ncheck++; if (vld4 !== 1'b0) $display("FAIL n4_valid_pulse got %b expected 0", vld4); else npass++;
    ncheck++; if (prod4 !== exp) $display("FAIL n4_product_hold got %0d expected %0d", prod4, exp); else npass++;
  endtask

  task automatic test_carry;
    logic [15:0] mb, kb;
    int nadd;
    mult16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, mb, kb, nadd);
    ncheck++; if (Valid !== 1'b1) $display("FAIL carry_valid got %b expected 1", Valid); else npass++;
    ncheck++; if (Product !== 32'hFFFE0001) $display("FAIL carry_product got %0h expected fffe0001", Product); else npass++;
    ncheck++; if (mb !== 16'hFFFF) $display("FAIL carry_m_pattern got %0h expected ffff", mb); else npass++;
    ncheck++; if (kb !== 16'h8000) $display("FAIL carry_k_pattern got %0h expected 8000", kb); else npass++;
    ncheck++; if (k !== 1'b0) $display("FAIL carry_k_wrap got %b expected 0", k); else npass++;
    tick();
    ncheck++; if (Valid !== 1'b0) $display("FAIL carry_valid_pulse got %b expected 0", Valid); else npass++;
  endtask

  task automatic test_zero;
    logic [15:0] mb, kb;
    int nadd;
    mult16(16'h0000, 16'h1234, 1'b0, 1'b1, mb, kb, nadd);
    ncheck++; if (nadd !== 0) $display("FAIL zero_adds got %0d expected 0", nadd); else npass++;
    ncheck++; if (Product !== 32'd0) $display("FAIL zero_product got %0h expected 0", Product); else npass++;
  endtask

  task automatic test_random;
    logic [15:0] a, b, mb, kb;
    logic [31:0] exp;
    int nadd;
    for (int t = 0; t < 6; t++) begin
      a = 16'($urandom); b = 16'($urandom);
      exp = 32'(a) * 32'(b);
      mult16(a, b, 1'($urandom), 1'b1, mb, kb, nadd);
      ncheck++; if (Product !== exp) $display("FAIL rand_product[%0d] got %0h expected %0h", t, Product, exp); else npass++;
      ncheck++; if (mb !== a) $display("FAIL rand_m_pattern[%0d] got %0h expected %0h", t, mb, a); else npass++;
    end
  endtask

  task automatic test_commands;
    logic [15:0] a, b;
    logic [16:0] up;
    logic [32:0] e33;
    a = 16'($urandom); b = 16'($urandom);
    Load = 1'b1; Ad = 1'b1; Sh = 1'b1; Mplier = a; Mcand = b;
    tick();
    Load = 1'b0; Ad = 1'b0; Sh = 1'b0;
    tick(); tick();
    ncheck++; if (M !== a[0]) $display("FAIL cmd_load_m got %b expected %b", M, a[0]); else npass++;
    Done = 1'b1; tick(); Done = 1'b0;
    ncheck++; if (Product !== {16'h0, a}) $display("FAIL cmd_load_prio got %0h expected %0h", Product, {16'h0, a}); else npass++;
    Ad = 1'b1; tick(); Ad = 1'b0;
    Done = 1'b1; tick(); Done = 1'b0;
    ncheck++; if (Product !== {b, a}) $display("FAIL cmd_add got %0h expected %0h", Product, {b, a}); else npass++;
    up  = 17'(b) + 17'(b);
    e33 = {up, a};
    Ad = 1'b1; tick(); Ad = 1'b0;
    Done = 1'b1; tick(); Done = 1'b0;
    ncheck++; if (Product !== e33[31:0]) $display("FAIL cmd_add2 got %0h expected %0h", Product, e33[31:0]); else npass++;
    e33 = e33 >> 1;
    Sh = 1'b1; tick(); Sh = 1'b0;
    Done = 1'b1; tick(); Done = 1'b0;
    ncheck++; if (Product !== e33[31:0]) $display("FAIL cmd_shift_carry got %0h expected %0h", Product, e33[31:0]); else npass++;
  endtask

  task automatic test_done_with_sh;
    logic [15:0] a, b;
    logic [31:0] exp;
    a = 16'($urandom); b = 16'($urandom);
    exp = model_partial(a, b, 5);
    Load = 1'b1; Mplier = a; Mcand = b; tick(); Load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Ad = M; Sh = 1'b1; tick(); Ad = 1'b0; Sh = 1'b0;
    end
    Sh = 1'b1; Done = 1'b1; tick(); Sh = 1'b0; Done = 1'b0;
    ncheck++; if (Product !== exp) $display("FAIL done_sh_product got %0h expected %0h", Product, exp); else npass++;
    ncheck++; if (Valid !== 1'b1) $display("FAIL done_sh_valid got %b expected 1", Valid); else npass++;
  endtask

  task automatic test_overshift;
    logic [15:0] a, b, mb, kb;
    logic [31:0] exp;
    int nadd;
    a = 16'($urandom); b = 16'($urandom);
    exp = (32'(a) * 32'(b)) >> 1;
    mult16(a, b, 1'b1, 1'b1, mb, kb, nadd);
    Sh = 1'b1; tick(); Sh = 1'b0;
    Done = 1'b1; tick(); Done = 1'b0;
    ncheck++; if (Product !== exp) $display("FAIL overshift_product got %0h expected %0h", Product, exp); else npass++;
    ncheck++; if (k !== 1'b0) $display("FAIL overshift_k_low got %b expected 0", k); else npass++;
    for (int i = 0; i < N - 2; i++) begin
      Sh = 1'b1; tick(); Sh = 1'b0;
    end
    ncheck++; if (k !== 1'b1) $display("FAIL overshift_k_wrap got %b expected 1", k); else npass++;
  endtask

  task automatic test_load_mid;
    logic [15:0] a, b, mb, kb;
    int nadd;
    a = 16'($urandom); b = 16'($urandom);
    exp_last = 32'(a) * 32'(b);
    mult16(a, b, 1'b0, 1'b1, mb, kb, nadd);
    Load = 1'b1; Mplier = 16'd7; Mcand = 16'd5; tick(); Load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Ad = M; Sh = 1'b1; tick(); Ad = 1'b0; Sh = 1'b0;
    end
    Load = 1'b1; Mplier = 16'd3; Mcand = 16'd3; tick(); Load = 1'b0;
    ncheck++; if (Product !== exp_last) $display("FAIL loadmid_product_kept got %0h expected %0h", Product, exp_last); else npass++;
    ncheck++; if (k !== 1'b0) $display("FAIL loadmid_k got %b expected 0", k); else npass++;
    mult16(16'd3, 16'd3, 1'b0, 1'b0, mb, kb, nadd);
    ncheck++; if (Product !== 32'd9) $display("FAIL loadmid_product got %0d expected 9", Product); else npass++;
    ncheck++; if (kb !== 16'h8000) $display("FAIL loadmid_cnt_restart got %0h expected 8000", kb); else npass++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] mb, kb;
    int nadd;
    Load = 1'b1; Mplier = 16'hB7F3; Mcand = 16'h9ACE; tick(); Load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Ad = M; Sh = 1'b1; tick(); Ad = 1'b0; Sh = 1'b0;
    end
    Ad = M; Sh = 1'b1; Done = 1'b1; Rst = 1'b1;
    tick();
    Ad = 1'b0; Sh = 1'b0; Done = 1'b0; Rst = 1'b0;
    ncheck++; if (Product !== 32'd0) $display("FAIL rstmid_product got %0h expected 0", Product); else npass++;
    ncheck++; if (Valid !== 1'b0) $display("FAIL rstmid_valid got %b expected 0", Valid); else npass++;
    ncheck++; if ({M, k} !== 2'b00) $display("FAIL rstmid_status got %b expected 00", {M, k}); else npass++;
    mult16(16'd6, 16'd7, 1'b0, 1'b1, mb, kb, nadd);
    ncheck++; if (Product !== 32'd42) $display("FAIL rstmid_rerun got %0d expected 42", Product); else npass++;
    ncheck++; if (kb !== 16'h8000) $display("FAIL rstmid_k_pattern got %0h expected 8000", kb); else npass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_normal_n4();
    test_carry();
    test_zero();
    test_random();
    test_commands();
    test_done_with_sh();
    test_overshift();
    test_load_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule

// File: doc/mul_datapath.md
# mul_datapath

Shift-and-add multiplier datapath: the responder side of the `Control_MUL` handshake. It executes the controller's `Load`, `Ad` and `Sh` commands on an accumulator/multiplier register and an operand register. It returns the two status bits the controller branches on: `M`, the current multiplier bit, and `k`, the last-shift flag. On `Done` it latches the finished product for the CPU's MULT path.

## Interface
- `N`, default 16: operand width in bits. Legal values are 2 and above. The product is 2N bits.
- `Clk`, input, 1 bit: the single clock. All state updates on the rising edge.
- `Rst`, input, 1 bit: reset, synchronous and active-high.
- `Load`, input, 1 bit: controller command to load the operands and clear the accumulator.
- `Ad`, input, 1 bit: controller command to add the multiplicand into the upper accumulator.
- `Sh`, input, 1 bit: controller command to shift the accumulator right by 1 and advance the counter.
- `Done`, input, 1 bit: controller indication that the operation is finished. Latches the product.
- `Mplier`, input, N bits: multiplier operand, sampled when `Load`=1.
- `Mcand`, input, N bits: multiplicand operand, sampled when `Load`=1.
- `M`, output, 1 bit: `ACC[0]`, the current multiplier bit sent to the controller.
- `k`, output, 1 bit: high when `cnt == N-1`. Tells the controller the next shift is the last one.
- `Product`, output, 2N bits: registered result.
- `Valid`, output, 1 bit: one-cycle pulse in the cycle after `Done` is sampled.

## Operation
- Registers:
  - `ACC`, 2N+1 bits. Bit 2N is the carry out of the add.
  - `MC`, N bits: stored multiplicand.
  - `cnt`, clog2(N) bits.
  - `Product`, 2N bits.
  - `Valid`, 1 bit.
- Command priority within one edge: `Rst` first, then `Load`, then `Ad`/`Sh`. `Done` is independent of the other commands.
- `Load`: `ACC` ← {(N+1)'b0, `Mplier`}, `MC` ← `Mcand`, `cnt` ← 0. Any `Ad`/`Sh` asserted in the same cycle is ignored.
- `Ad` alone: `ACC[2N:N]` ← `ACC[2N-1:N]` + `MC`, computed at N+1 bits. `ACC[N-1:0]` is unchanged.
- `Sh` alone: `ACC` ← {1'b0, `ACC[2N:1]`}, then `cnt` ← `cnt`+1, wrapping modulo 2^clog2(N).
- `Ad` and `Sh` together: one cycle does the add and then the shift of the sum. `cnt` increments.
- No command: all of `ACC`, `MC` and `cnt` hold.
- `Done`: `Product` ← `ACC[2N-1:0]` and `Valid` ← 1. Otherwise `Valid` ← 0. `Product` holds its value until the next `Done`.
- `M` and `k` are combinational from registers only, with no input-to-output path. This prevents combinational loops with the controller.
- Result: after N add/shift iterations, `ACC[2N-1:0]` = `Mplier` × `Mcand`, unsigned.

## Timing
- Reset values: `ACC`=0, `MC`=0, `cnt`=0, `Product`=0, `Valid`=0. Therefore `M`=0, and `k`=0 when N>1.
- Command latency: every command takes effect at the edge where it is sampled. `M` and `k` reflect the new state in the following cycle.
- Full multiply time: Load takes 1 cycle, then N shifts plus up to N separate add cycles, then Done. This is 2N+2 cycles worst case with a 4-state controller.
- `k` rises after N-1 shifts and falls after the Nth shift (`cnt` wraps to 0 when N is a power of 2).
- A `Load` in mid-operation aborts the current product and restarts cleanly. `Product` is not touched.
- `Rst` in mid-operation clears everything at that edge. `Done` in the same cycle as `Rst` is ignored.
- `Done` in the same cycle as `Sh` latches the pre-shift `ACC`. The controller must not do this; it is listed here only for verification.
- Shifts beyond N (controller fault) keep shifting. No saturation and no error flag.

## Structure
- `mul_pkg` holds `MUL_N` (16), `MUL_CNT_W` = clog2(`MUL_N`), and the command-bundle typedef {`Load`, `Ad`, `Sh`, `Done`}. The same typedef is shared with `Control_MUL`.
- The block has one sub-module, `mul_shift_counter`: the `cnt` register, its increment on `Sh`, its clear on `Load`/`Rst`, and the `k` decode.
- Target size is about 150–250 lines of RTL. A top-level wrapper pairs this block with `Control_MUL`.

## Test plan
- **Reset:** hold `Rst` for 2 cycles with random commands → `Product`=0, `Valid`=0, `M`=0, `k`=0.
- **Normal multiply (N=4):** `Mplier`=13, `Mcand`=11, drive the standard Load/Ad/Sh sequence → `M` pattern is 1,0,1,1, `k` is high on the 4th shift only, and on `Done` `Product`=143 with `Valid` high for exactly 1 cycle.
- **Carry path (N=16):** 0xFFFF × 0xFFFF with combined `Ad`+`Sh` cycles → `Product`=0xFFFE0001. The `ACC[2N]` carry is exercised.
- **Zero operand (N=16):** 0 × 0x1234 → no `Ad` cycles, because `M` is always 0, and `Product`=0.
- **Load mid-operation:** after 2 shifts of 7×5, assert `Load` with 3×3 → final `Product`=9 and `cnt` restarts at 0.
- **Reset mid-operation:** assert `Rst` during shift 3 → all registers 0 on the next cycle. A subsequent 6×7 run gives 42.
